// File: rtl/udp_transmit_fragmenter.sv
// Round-robin datagram source arbiter that splits each payload into IPv4 fragments,
// presenting a header descriptor per fragment followed by a registered byte stream.
module udp_transmit_fragmenter #(
    parameter int          TRANSMIT_QUE_SLOTS = 4,
    parameter int          MAX_FRAGMENT_BYTES = 1480,
    parameter logic [15:0] TIMEOUT_LIMIT      = 16'h004
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [TRANSMIT_QUE_SLOTS-1:0]       enable,
    input  logic [TRANSMIT_QUE_SLOTS-1:0][15:0] payload_length,
    input  logic [TRANSMIT_QUE_SLOTS-1:0][7:0]  data,
    input  logic [TRANSMIT_QUE_SLOTS-1:0]       data_enable,
    output logic [TRANSMIT_QUE_SLOTS-1:0]       data_ready,
    output logic [TRANSMIT_QUE_SLOTS-1:0]       slot_done,
    output logic                                fragment_start,
    input  logic                                fragment_ready,
    output logic [15:0]                         ipv4_identification,
    output logic [15:0]                         ipv4_flags,
    output logic [15:0]                         fragment_length,
    output logic [7:0]                          tx_data,
    output logic                                tx_data_valid,
    output logic                                tx_data_last,
    input  logic                                tx_data_ready,
    output logic                                tx_abort
);

    localparam int                N        = TRANSMIT_QUE_SLOTS;
    localparam int                SEL_W    = $clog2(N);
    localparam logic [15:0]       MAX_LEN  = 16'(MAX_FRAGMENT_BYTES);
    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_HEADER = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state;
    logic [SEL_W-1:0] sel;
    logic [15:0]      id_counter;
    logic [15:0]      remaining;
    logic [12:0]      frag_offset;
    logic [15:0]      byte_count;
    logic [15:0]      idle_timer;

    logic [N-1:0]     sel_onehot;
    logic [SEL_W-1:0] next_sel;
    logic             out_accept;
    logic             issue;
    logic             idle;
    logic             timeout;
    logic             frag_end;

    function automatic logic [15:0] fragment_size(input logic [15:0] left);
        return (left > MAX_LEN) ? MAX_LEN : left;
    endfunction

    assign sel_onehot = N'(1) << sel;
    assign next_sel   = (sel == LAST_SEL) ? '0 : sel + 1'b1;
    assign out_accept = tx_data_valid && tx_data_ready;

    // A new byte may enter the output register only when it is empty or draining.
    assign issue    = (state == S_STREAM) && (!tx_data_valid || tx_data_ready)
                      && data_enable[sel] && (byte_count < fragment_length);
    assign idle     = (state == S_STREAM) && !issue && !tx_data_valid;
    assign timeout  = idle && (idle_timer == TIMEOUT_LIMIT - 16'd1);
    assign frag_end = (state == S_STREAM) && out_accept && tx_data_last;

    assign data_ready = issue ? sel_onehot : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            sel                 <= '0;
            id_counter          <= '0;
            remaining           <= '0;
            frag_offset         <= '0;
            byte_count          <= '0;
            idle_timer          <= '0;
            slot_done           <= '0;
            fragment_start      <= 1'b0;
            ipv4_identification <= '0;
            ipv4_flags          <= '0;
            fragment_length     <= '0;
            tx_data             <= '0;
            tx_data_valid       <= 1'b0;
            tx_data_last        <= 1'b0;
            tx_abort            <= 1'b0;
        end else begin
            slot_done <= '0;
            tx_abort  <= 1'b0;
            if (out_accept) begin
                tx_data_valid <= 1'b0;
                tx_data_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (enable[sel] && payload_length[sel] != 16'd0) begin
                        remaining   <= payload_length[sel];
                        frag_offset <= '0;
                        state       <= S_LOAD;
                    end else begin
                        // Empty datagrams complete immediately without consuming an ID.
                        if (enable[sel]) slot_done <= sel_onehot;
                        sel <= next_sel;
                    end
                end

                S_LOAD: begin
                    fragment_length     <= fragment_size(remaining);
                    ipv4_flags          <= {2'b00, (remaining > MAX_LEN), frag_offset};
                    ipv4_identification <= id_counter;
                    fragment_start      <= 1'b1;
                    state               <= S_HEADER;
                end

                S_HEADER: begin
                    if (fragment_ready) begin
                        fragment_start <= 1'b0;
                        byte_count     <= '0;
                        idle_timer     <= '0;
                        state          <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (issue) begin
                        tx_data       <= data[sel];
                        tx_data_valid <= 1'b1;
                        tx_data_last  <= (byte_count == fragment_length - 16'd1);
                        byte_count    <= byte_count + 16'd1;
                        idle_timer    <= '0;
                    end else if (idle) begin
                        idle_timer <= idle_timer + 16'd1;
                    end else begin
                        idle_timer <= '0;
                    end

                    if (timeout) begin
                        tx_abort      <= 1'b1;
                        tx_data_valid <= 1'b0;
                        tx_data_last  <= 1'b0;
                        slot_done     <= sel_onehot;
                        state         <= S_DONE;
                    end else if (frag_end) begin
                        remaining   <= remaining - fragment_length;
                        frag_offset <= frag_offset + fragment_length[15:3];
                        if (remaining == fragment_length) begin
                            slot_done <= sel_onehot;
                            state     <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end

                S_DONE: begin
                    id_counter <= id_counter + 16'd1;
                    sel        <= next_sel;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
